// File: rtl/sample_decimator.sv
// ==== sample_decimator : boxcar floor-average decimator, one held sample per 2**LOG2_RATIO valid inputs
// ==== rev 1.0
`default_nettype none

module sample_decimator #(
  parameter int BITS       = 16,
  parameter int LOG2_RATIO = 4,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BITS-1:0]       in_data,
  input  logic                  in_valid,
  output logic [BITS-1:0]       out_data,
  output logic                  out_valid,
  output logic [COUNT_BITS-1:0] sample_count,
  output logic                  busy
);

  localparam int c_acc_w = BITS + LOG2_RATIO;
  localparam logic [LOG2_RATIO-1:0] c_last_cnt = LOG2_RATIO'((2 ** LOG2_RATIO) - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                  r_state,     w_state_nxt;
  logic [c_acc_w-1:0]      r_acc,       w_acc_nxt;
  logic [LOG2_RATIO-1:0]   r_cnt,       w_cnt_nxt;
  logic [BITS-1:0]         r_out_data,  w_out_data_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic [COUNT_BITS-1:0]   r_count,     w_count_nxt;

  logic [c_acc_w-1:0]      w_in_ext;
  logic [c_acc_w-1:0]      w_sum;
  logic                    w_last;

  // Sign-extended input guarantees the accumulator can hold RATIO full-scale samples.
  assign w_in_ext = {{LOG2_RATIO{in_data[BITS-1]}}, in_data};
  assign w_sum    = r_acc + w_in_ext;
  assign w_last   = (r_cnt == c_last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_count     <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_count_nxt     = r_count;

    if (!enable) begin
      // Enable dominates a window-completing sample: the window is simply dropped.
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = S_ACCUM;
            w_acc_nxt   = w_in_ext;
            w_cnt_nxt   = LOG2_RATIO'(1);
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (w_last) begin
              // Taking the upper BITS of the sum is the arithmetic right shift, floor rounded.
              w_out_data_nxt  = w_sum[c_acc_w-1:LOG2_RATIO];
              w_out_valid_nxt = 1'b1;
              w_count_nxt     = r_count + COUNT_BITS'(1);
              w_acc_nxt       = '0;
              w_cnt_nxt       = '0;
            end else begin
              w_acc_nxt = w_sum;
              w_cnt_nxt = r_cnt + LOG2_RATIO'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign sample_count = r_count;
  assign busy         = (r_state == S_ACCUM) && (r_cnt != '0);

endmodule

`default_nettype wire
